// File: rtl/display_scan.sv
// Purpose: 4-digit multiplexed 7-segment scanner; optional inter-digit blanking when DISPLAY_SCAN_DEADTIME_EN is defined.
// Latency: an/seg/frame_done are registered and follow state on the same edge; new data appears at the next frame boundary.
// Backpressure: wr_ready drops while one captured value waits for a frame boundary; further writes stall.
module display_scan #(
    parameter int DIV  = 50000,
    parameter int DEAD = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  digit_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);
    localparam int MAXC = (DIV > DEAD) ? DIV : DEAD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

`ifdef DISPLAY_SCAN_DEADTIME_EN
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

    state_t      state, nxt_state;
    logic [1:0]  idx, nxt_idx;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [15:0] disp, nxt_disp, shadow;
    logic        pending, wrap, load;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            4'hF: return 7'h71;
        endcase
    endfunction

    assign wr_ready = ~pending;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        wrap      = 1'b0;
        if (!en) begin
            nxt_state = IDLE;
            nxt_idx   = 2'd0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = SHOW;
                    nxt_idx   = 2'd0;
                    nxt_cnt   = '0;
                end
                SHOW: begin
                    if (cnt == CW'(DIV - 1)) begin
                        nxt_cnt = '0;
`ifdef DISPLAY_SCAN_DEADTIME_EN
                        nxt_state = BLANK;
`else
                        nxt_idx = idx + 2'd1;
                        wrap    = (idx == 2'd3);
`endif
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
`ifdef DISPLAY_SCAN_DEADTIME_EN
                BLANK: begin
                    if (cnt == CW'(DEAD - 1)) begin
                        nxt_state = SHOW;
                        nxt_idx   = idx + 2'd1;
                        nxt_cnt   = '0;
                        wrap      = (idx == 2'd3);
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    nxt_state = IDLE;
                    nxt_idx   = 2'd0;
                    nxt_cnt   = '0;
                end
            endcase
        end
        // Only data already pending when the boundary arrives is loaded.
        load     = pending & (wrap | (state == IDLE));
        nxt_disp = load ? shadow : disp;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            an         <= 4'b0000;
            seg        <= 7'h00;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            disp       <= nxt_disp;
            frame_done <= wrap;
            if (wr_valid && !pending) begin
                shadow  <= wr_data;
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
            // Outputs are computed from next-state so they line up with state.
            if (nxt_state == SHOW && digit_mask[nxt_idx]) begin
                an  <= 4'b0001 << nxt_idx;
                seg <= hex7(nxt_disp[{nxt_idx, 2'b00} +: 4]);
            end else begin
                an  <= 4'b0000;
                seg <= 7'h00;
            end
        end
    end
endmodule
